uart_receiver: RTL

//  - Serial-to-parallel UART receiver, 8N1, LSB first; the far-end consumer of the UART TX serial line.
//  - Synchronises RX, validates the start bit at mid-bit, and samples each data and stop bit at its centre.
//  - Holds each received byte with a VALID/RD handshake.
//  - Flags framing errors and overruns.

---
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 77 +++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus byte handshake between the UART receiver and its consumer.
interface uart_receiver_if;
   logic       rx;
   logic       rd;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   modport master (output rx, rd, input data, valid, frame_err, overrun, busy);
   modport slave (input rx, rd, output data, valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with centre sampling, VALID/RD byte handshake,
// framing-error pulse and sticky overrun flag.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 1250
) (
   input logic           clk,
   input logic           rst,
   uart_receiver_if.slave bus
);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t        state, next;
   logic [1:0]    sync;
   logic          rx_s, tick, accept;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg, rx_byte;
   logic          valid, overrun;
   assign rx_s = sync[1];
   // START waits half a bit to reach the start-bit centre; later states wait whole bits
   assign tick = (state == START) ? (cnt == CW'(HALF_BIT - 1)) : (cnt == CW'(CLKS_PER_BIT - 1));
   assign accept = (state == STOP) && tick && rx_s;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:  next = rx_s ? IDLE : START;
         START: next = tick ? (rx_s ? IDLE : DATA) : START;
         DATA:  next = (tick && idx == 3'd7) ? STOP : DATA;
         STOP:  next = tick ? (rx_s ? IDLE : BRK) : STOP;
         BRK:   next = rx_s ? IDLE : BRK;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      bus.busy = state != IDLE;
      bus.frame_err = (state == STOP) && tick && !rx_s;
      bus.data = rx_byte;
      bus.valid = valid;
      bus.overrun = overrun;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
         cnt <= '0;
         idx <= '0;
         shreg <= '0;
         rx_byte <= '0;
         valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         sync <= {sync[0], bus.rx};
         cnt <= (state == IDLE || state == BRK || tick) ? '0 : cnt + 1'b1;
         if (state == START && tick) idx <= '0;
         if (state == DATA && tick) begin
            shreg <= {rx_s, shreg[7:1]};
            idx <= idx + 1'b1;
         end
         // a read in the acceptance cycle makes room for the new byte instead of clearing it
         if (accept) begin
            if (!valid || bus.rd) begin
               rx_byte <= shreg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (bus.rd) begin
            valid <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end
endmodule
